wb_rr_arbiter: RTL and testbench
================================

// Module: wb_rr_arbiter
// PURPOSE
//  Registered round-robin bus arbiter for the shared wishbone interconnect: picks one owner among N_MASTER
//  requesters, honours wb_lock, pre-empts unlocked owners after MAX_BURST terminations when others wait, and
//  revokes a grant via a stall watchdog. Its one-hot grant drives the crossbar's master mux and the masters' wb_gnt.
// PARAMETERS
//  N_MASTER     4    number of requesting masters (>=2)
//  MAX_BURST    8    terminations an unlocked owner may complete before rotation if others request; 0 = never pre-empt
//  TIMEOUT_CYC  256  cycles owner stb may stay unanswered before revocation; 0 = watchdog disabled
//  IDX_W        $clog2(N_MASTER) localparam, grant index width
// PORTS
//  clk_i          in   1         clock, all state on rising edge
//  rst_ni         in   1         reset, asynchronous, active low
//  cyc_i          in   N_MASTER  per-master wb_cyc (request)
//  stb_i          in   N_MASTER  per-master wb_stb
//  lock_i         in   N_MASTER  per-master wb_lock
//  ack_i          in   1         muxed slave ack for current owner
//  err_i          in   1         muxed slave err
//  rty_i          in   1         muxed slave rty
//  gnt_o          out  N_MASTER  one-hot grant, registered, 0 when no owner
//  gnt_idx_o      out  IDX_W     index of owner, valid when gnt_valid_o
//  gnt_valid_o    out  1         an owner exists (= |gnt_o)
//  locked_o       out  1         current ownership is locked
//  tmo_err_o      out  1         one-cycle pulse: inject wb_err to owner, watchdog expired
// BEHAVIOUR
//  Reset (rst_ni=0, async): state IDLE, gnt_o=0, gnt_idx_o=0, gnt_valid_o=0, locked_o=0, tmo_err_o=0,
//   rr pointer=0, burst cnt=0, wdog cnt=0, mask=0. Reset mid-transfer drops grant immediately.
//  term = ack_i|err_i|rty_i; elig = cyc_i & ~mask. Round robin: search elig starting at ptr, wrapping
//   N_MASTER-1 -> 0; on every grant, ptr <= granted index + 1 (mod N_MASTER).
//  States:
//   IDLE:   elig!=0 at cycle t -> GRANT (or LOCKED if lock_i[winner]) with gnt_o valid at t+1. Else stay.
//   GRANT:  owner cyc_i low -> handover: if other elig, grant next rr winner at t+1 (no idle cycle), else IDLE.
//           owner lock_i high -> LOCKED (no owner change). burst cnt += term; if MAX_BURST!=0, cnt reaches
//           MAX_BURST and (elig & ~owner)!=0 -> grant next rr winner at t+1 (pre-empt); cnt saturates otherwise.
//   LOCKED: locked_o=1; no pre-emption, no rotation; leaves only when owner cyc_i drops (then as GRANT handover)
//           or on watchdog expiry. lock_i dropping with cyc_i high -> back to GRANT, burst cnt cleared.
//   TMO:    entered when wdog cnt == TIMEOUT_CYC-1 and no term; tmo_err_o=1 for exactly that cycle, gnt_o still
//           set; next cycle gnt_o=0, mask[owner]<=1, then arbitrate like IDLE. mask bit clears when that master's
//           cyc_i is low for one cycle.
//  Watchdog: counts cycles with owner stb_i=1 and term=0; clears on term, owner change, or owner stb_i=0.
//   Watchdog applies in GRANT and LOCKED.
//  Burst cnt and wdog cnt clear on every owner change; gnt_o always one-hot or zero, never changes combinationally.
//  Simultaneous: term in the same cycle as owner cyc_i drop counts, handover still next cycle; timeout and term
//   in same cycle -> term wins, no tmo. Requests appearing while owner holds are only served at handover.
// TESTING
//  1 reset: cyc_i=4'b1111 during rst_ni=0 -> gnt_o=0; release -> gnt_o=4'b0001 one cycle later.
//  2 rr: cyc_i=4'b1010, owners release after 1 ack each -> grant order 0010,1000,0010 with no idle cycles.
//  3 pre-empt: MAX_BURST=2, m0 holds cyc, m2 requests -> after 2nd ack gnt_o=4'b0100 next cycle.
//  4 lock: m1 lock_i=1, m3 requests, 20 acks -> gnt_o stays 0010, locked_o=1; m1 cyc drop -> gnt_o=1000.
//  5 watchdog: TIMEOUT_CYC=16, owner m0 stb high, no ack -> tmo_err_o pulse on 16th cycle, gnt_o=0 next,
//    m0 masked until cyc drop, m1 granted if requesting.
//  6 async reset asserted mid-LOCKED burst -> all outputs 0 in same cycle, no tmo_err_o glitch.

Source files
------------

// File: rtl/wb_rr_arbiter_if.sv
// Request/grant bundle between the wishbone masters and the round-robin arbiter.
// "master" is the requester side that drives cyc/stb/lock and the muxed slave
// responses. "slave" is the arbiter side that returns the registered grant.
interface wb_rr_arbiter_if #(
  parameter int N_MASTER = 4
);
  localparam int IDX_W = (N_MASTER > 1) ? $clog2(N_MASTER) : 1;

  logic [N_MASTER-1:0] cyc_i;
  logic [N_MASTER-1:0] stb_i;
  logic [N_MASTER-1:0] lock_i;
  logic                ack_i;
  logic                err_i;
  logic                rty_i;
  logic [N_MASTER-1:0] gnt_o;
  logic [IDX_W-1:0]    gnt_idx_o;
  logic                gnt_valid_o;
  logic                locked_o;
  logic                tmo_err_o;

  modport master (
    output cyc_i, stb_i, lock_i, ack_i, err_i, rty_i,
    input  gnt_o, gnt_idx_o, gnt_valid_o, locked_o, tmo_err_o
  );

  modport slave (
    input  cyc_i, stb_i, lock_i, ack_i, err_i, rty_i,
    output gnt_o, gnt_idx_o, gnt_valid_o, locked_o, tmo_err_o
  );
endinterface

// File: rtl/wb_rr_arbiter.sv
// Registered round-robin wishbone arbiter.
// - Picks one owner among N_MASTER requesters.
// - Honours wb_lock.
// - Pre-empts an unlocked owner after MAX_BURST terminations when others wait.
// - Revokes a stalled grant through a watchdog that raises a one-cycle tmo_err
//   and masks the offender until it drops cyc.
module wb_rr_arbiter #(
  parameter int N_MASTER    = 4,
  parameter int MAX_BURST   = 8,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  wb_rr_arbiter_if.slave bus
);

  localparam int IDX_W  = (N_MASTER > 1) ? $clog2(N_MASTER) : 1;
  localparam int BCNT_W = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
  localparam int WCNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  localparam bit                BURST_EN  = (MAX_BURST > 0);
  localparam bit                WDOG_EN   = (TIMEOUT_CYC > 0);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_MASTER - 1);
  localparam logic [BCNT_W:0]   BURST_LIM = (BCNT_W + 1)'(MAX_BURST);
  localparam logic [WCNT_W-1:0] WDOG_LAST = WCNT_W'((TIMEOUT_CYC > 0) ? (TIMEOUT_CYC - 1) : 0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GRANT  = 2'd1,
    S_LOCKED = 2'd2,
    S_TMO    = 2'd3
  } state_t;

  state_t              r_state,  w_state_next;
  logic [N_MASTER-1:0] r_gnt,    w_gnt_next;
  logic [N_MASTER-1:0] r_mask,   w_mask_next;
  logic [IDX_W-1:0]    r_idx,    w_idx_next;
  logic [IDX_W-1:0]    r_ptr,    w_ptr_next;
  logic [BCNT_W-1:0]   r_bcnt,   w_bcnt_next;
  logic [WCNT_W-1:0]   r_wdog,   w_wdog_next;

  logic                w_term;
  logic [N_MASTER-1:0] w_elig;
  logic [N_MASTER-1:0] w_others;
  logic                w_own_cyc;
  logic                w_own_stb;
  logic                w_own_lock;
  logic                w_stall;
  logic                w_tmo_hit;
  logic [BCNT_W:0]     w_bcnt_sum;
  logic                w_burst_done;
  logic [BCNT_W-1:0]   w_bcnt_sat;
  logic [WCNT_W-1:0]   w_wdog_step;
  logic [IDX_W-1:0]    w_cand [N_MASTER];
  logic                w_win_found;
  logic [IDX_W-1:0]    w_win_idx;
  logic [N_MASTER-1:0] w_win_oh;
  logic [IDX_W-1:0]    w_win_ptr;
  logic                w_win_lock;
  logic                w_take;

  // Any slave termination for the current owner ends one beat.
  assign w_term = bus.ack_i | bus.err_i | bus.rty_i;

  // A timed-out master stays out of arbitration until it has released cyc.
  assign w_elig = bus.cyc_i & ~r_mask;

  // The owner is excluded so that a handover or pre-emption always moves on.
  // In IDLE r_gnt is zero, so this is the full eligible set.
  assign w_others = w_elig & ~r_gnt;

  assign w_own_cyc  = |(bus.cyc_i  & r_gnt);
  assign w_own_stb  = |(bus.stb_i  & r_gnt);
  assign w_own_lock = |(bus.lock_i & r_gnt);

  // Watchdog: a cycle is stalled when the owner strobes and nothing answers.
  assign w_stall     = w_own_stb & ~w_term;
  assign w_tmo_hit   = WDOG_EN && w_stall && (r_wdog == WDOG_LAST);
  assign w_wdog_step = (WDOG_EN && w_stall) ? (r_wdog + WCNT_W'(1)) : '0;

  // Burst accounting: count terminations, saturate at the limit so that a
  // late-arriving requester can still pre-empt an owner that is already over.
  assign w_bcnt_sum   = {1'b0, r_bcnt} + (BCNT_W + 1)'(w_term);
  assign w_burst_done = BURST_EN && (w_bcnt_sum >= BURST_LIM);
  assign w_bcnt_sat   = !BURST_EN    ? '0 :
                        w_burst_done ? BURST_LIM[BCNT_W-1:0] :
                                       w_bcnt_sum[BCNT_W-1:0];

  // Search order: candidate k is (ptr + k) mod N_MASTER, so the scan starts at the
  // pointer and wraps from N_MASTER-1 back to 0.
  generate
    for (genvar gi = 0; gi < N_MASTER; gi++) begin : g_cand
      localparam logic [IDX_W:0] OFS = (IDX_W + 1)'(gi);
      localparam logic [IDX_W:0] NM  = (IDX_W + 1)'(N_MASTER);
      logic [IDX_W:0] w_sum;
      assign w_sum       = {1'b0, r_ptr} + OFS;
      assign w_cand[gi]  = IDX_W'((w_sum >= NM) ? (w_sum - NM) : w_sum);
    end
  endgenerate

  // Round-robin pick: the first eligible candidate in search order wins.
  always_comb begin
    w_win_found = 1'b0;
    w_win_idx   = '0;
    for (int k = 0; k < N_MASTER; k++) begin
      if (!w_win_found && w_others[w_cand[k]]) begin
        w_win_found = 1'b1;
        w_win_idx   = w_cand[k];
      end
    end
  end

  assign w_win_oh   = {{(N_MASTER-1){1'b0}}, 1'b1} << w_win_idx;
  assign w_win_ptr  = (w_win_idx == LAST_IDX) ? '0 : (w_win_idx + IDX_W'(1));
  assign w_win_lock = |(bus.lock_i & w_win_oh);

  // Next-state logic.
  // Priority for an active owner, highest first:
  //   1. cyc release (handover)
  //   2. watchdog expiry
  //   3. lock changes
  //   4. pre-emption
  always_comb begin
    w_state_next = r_state;
    w_gnt_next   = r_gnt;
    w_idx_next   = r_idx;
    w_ptr_next   = r_ptr;
    w_bcnt_next  = r_bcnt;
    w_wdog_next  = r_wdog;
    w_mask_next  = r_mask & bus.cyc_i;
    w_take       = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_take = w_win_found;
      end

      S_GRANT, S_LOCKED: begin
        if (!w_own_cyc) begin
          // Owner finished: hand straight over, or go idle if nobody waits.
          if (w_win_found) begin
            w_take = 1'b1;
          end else begin
            w_state_next = S_IDLE;
            w_gnt_next   = '0;
            w_bcnt_next  = '0;
            w_wdog_next  = '0;
          end
        end else if (w_tmo_hit) begin
          // Grant stays up through the error pulse and is withdrawn after it.
          w_state_next = S_TMO;
          w_bcnt_next  = '0;
          w_wdog_next  = '0;
        end else if (r_state == S_LOCKED) begin
          w_wdog_next = w_wdog_step;
          if (!w_own_lock) begin
            w_state_next = S_GRANT;
            w_bcnt_next  = '0;
          end
        end else if (w_own_lock) begin
          w_state_next = S_LOCKED;
          w_bcnt_next  = '0;
          w_wdog_next  = w_wdog_step;
        end else if (w_burst_done && w_win_found) begin
          w_take = 1'b1;
        end else begin
          w_bcnt_next = w_bcnt_sat;
          w_wdog_next = w_wdog_step;
        end
      end

      S_TMO: begin
        w_state_next = S_IDLE;
        w_gnt_next   = '0;
        w_mask_next  = (r_mask & bus.cyc_i) | r_gnt;
        w_bcnt_next  = '0;
        w_wdog_next  = '0;
      end

      default: begin
        w_state_next = S_IDLE;
        w_gnt_next   = '0;
      end
    endcase

    // Every new ownership starts with fresh counters and advances the pointer.
    if (w_take) begin
      w_state_next = w_win_lock ? S_LOCKED : S_GRANT;
      w_gnt_next   = w_win_oh;
      w_idx_next   = w_win_idx;
      w_ptr_next   = w_win_ptr;
      w_bcnt_next  = '0;
      w_wdog_next  = '0;
    end
  end

  // State and counter registers; reset drops any grant immediately.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_mask  <= '0;
      r_idx   <= '0;
      r_ptr   <= '0;
      r_bcnt  <= '0;
      r_wdog  <= '0;
    end else begin
      r_state <= w_state_next;
      r_gnt   <= w_gnt_next;
      r_mask  <= w_mask_next;
      r_idx   <= w_idx_next;
      r_ptr   <= w_ptr_next;
      r_bcnt  <= w_bcnt_next;
      r_wdog  <= w_wdog_next;
    end
  end

  // All outputs come straight from registers, so none of them follows an input
  // combinationally.
  assign bus.gnt_o       = r_gnt;
  assign bus.gnt_idx_o   = r_idx;
  assign bus.gnt_valid_o = |r_gnt;
  assign bus.locked_o    = (r_state == S_LOCKED);
  assign bus.tmo_err_o   = (r_state == S_TMO);

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Bench for wb_rr_arbiter.
// Directed scenarios cover reset, rotation, pre-emption, locking, the watchdog
// and async reset. They are followed by randomized traffic. Every cycle the DUT
// outputs are compared with a behavioural ownership model.
module tb_wb_rr_arbiter;
  localparam int N  = 4;
  localparam int MB = 2;
  localparam int TO = 16;

  logic clk    = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  wb_rr_arbiter_if #(.N_MASTER(N)) bus ();

  wb_rr_arbiter #(
    .N_MASTER   (N),
    .MAX_BURST  (MB),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_ni),
    .bus   (bus.slave)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Behavioural model of ownership, kept as plain integers.
  int          m_owner;    // -1 when nobody owns the bus
  bit          m_locked;
  bit          m_revoke;   // current cycle is the tmo_err pulse
  int          m_ptr;
  int          m_burst;
  int          m_stall;
  logic [N-1:0] m_mask;
  logic [N-1:0] prev_gnt = '0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] req, input int start);
    for (int k = 0; k < N; k++) begin
      if (req[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner  = -1;
    m_locked = 1'b0;
    m_revoke = 1'b0;
    m_ptr    = 0;
    m_burst  = 0;
    m_stall  = 0;
    m_mask   = '0;
  endtask

  task automatic give(input int w);
    m_owner  = w;
    m_ptr    = (w + 1) % N;
    m_locked = bus.lock_i[w];
    m_burst  = 0;
    m_stall  = 0;
  endtask

  // Advance the model over one rising edge using the inputs currently driven.
  task automatic model_step();
    logic [N-1:0] c        = bus.cyc_i;
    logic [N-1:0] new_mask = m_mask & bus.cyc_i;
    logic [N-1:0] req      = bus.cyc_i & ~m_mask;
    logic [N-1:0] own_oh;
    bit           term     = bus.ack_i | bus.err_i | bus.rty_i;
    bit           stall;
    int           w;

    if (!rst_ni) begin
      model_reset();
      return;
    end

    if (m_revoke) begin
      new_mask[m_owner] = 1'b1;
      m_owner  = -1;
      m_revoke = 1'b0;
      m_locked = 1'b0;
    end else if (m_owner < 0) begin
      w = rr_pick(req, m_ptr);
      if (w >= 0) give(w);
    end else begin
      own_oh = '0;
      own_oh[m_owner] = 1'b1;
      stall = bus.stb_i[m_owner] && !term;
      w = rr_pick(req & ~own_oh, m_ptr);
      if (!c[m_owner]) begin
        if (w >= 0) begin
          give(w);
        end else begin
          m_owner  = -1;
          m_locked = 1'b0;
        end
      end else if (stall && m_stall == TO - 1) begin
        m_revoke = 1'b1;
      end else if (m_locked) begin
        m_stall = stall ? m_stall + 1 : 0;
        if (!bus.lock_i[m_owner]) begin
          m_locked = 1'b0;
          m_burst  = 0;
        end
      end else if (bus.lock_i[m_owner]) begin
        m_locked = 1'b1;
        m_burst  = 0;
        m_stall  = stall ? m_stall + 1 : 0;
      end else begin
        m_burst = m_burst + int'(term);
        if (m_burst >= MB && w >= 0) begin
          give(w);
        end else begin
          if (m_burst > MB) m_burst = MB;
          m_stall = stall ? m_stall + 1 : 0;
        end
      end
    end
    m_mask = new_mask;
  endtask

  task automatic check_outputs(input string ctx);
    logic [N-1:0] eg = '0;
    if (m_owner >= 0) eg[m_owner] = 1'b1;
    check_val({ctx, ".gnt"},    32'(bus.gnt_o),       32'(eg));
    check_val({ctx, ".valid"},  32'(bus.gnt_valid_o), 32'(m_owner >= 0));
    check_val({ctx, ".locked"}, 32'(bus.locked_o),    32'(m_owner >= 0 && m_locked && !m_revoke));
    check_val({ctx, ".tmo"},    32'(bus.tmo_err_o),   32'(m_revoke));
    if (m_owner >= 0) check_val({ctx, ".idx"}, 32'(bus.gnt_idx_o), 32'(m_owner));
    if (bus.gnt_o !== prev_gnt) begin
      $display("[%0t] %s: grant %b -> %b locked=%0b tmo=%0b",
               $time, ctx, prev_gnt, bus.gnt_o, bus.locked_o, bus.tmo_err_o);
      prev_gnt = bus.gnt_o;
    end
  endtask

  task automatic tick(input string ctx);
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_outputs(ctx);
  endtask

  task automatic drive(input logic [N-1:0] c, input logic [N-1:0] s, input logic [N-1:0] l,
                       input logic a, input logic e, input logic r);
    bus.cyc_i  = c;
    bus.stb_i  = s;
    bus.lock_i = l;
    bus.ack_i  = a;
    bus.err_i  = e;
    bus.rty_i  = r;
  endtask

  task automatic apply_reset();
    drive('0, '0, '0, 1'b0, 1'b0, 1'b0);
    rst_ni = 1'b0;
    model_reset();
    @(negedge clk);
    check_outputs("reset");
    rst_ni = 1'b1;
  endtask

  logic [N-1:0] rc, rs, rl, want_lock;
  bit           quiet;

  initial begin
    drive('0, '0, '0, 1'b0, 1'b0, 1'b0);
    model_reset();
    @(negedge clk);

    // 1: requests during reset are ignored; the first grant follows release.
    drive(4'b1111, 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0);
    repeat (3) tick("t1_rst");
    check_val("t1_rst_gnt", 32'(bus.gnt_o), 32'h0);
    check_val("t1_rst_idx", 32'(bus.gnt_idx_o), 32'h0);
    rst_ni = 1'b1;
    tick("t1");
    check_val("t1_first_gnt", 32'(bus.gnt_o), 32'b0001);

    // 2: rotation between m1 and m3 with no idle cycle.
    apply_reset();
    drive(4'b1010, 4'b1010, 4'b0000, 1'b0, 1'b0, 1'b0); tick("t2");
    check_val("t2_gnt_a", 32'(bus.gnt_o), 32'b0010);
    drive(4'b1010, 4'b1010, 4'b0000, 1'b1, 1'b0, 1'b0); tick("t2");
    drive(4'b1000, 4'b1000, 4'b0000, 1'b0, 1'b0, 1'b0); tick("t2");
    check_val("t2_gnt_b", 32'(bus.gnt_o), 32'b1000);
    drive(4'b1010, 4'b1010, 4'b0000, 1'b1, 1'b0, 1'b0); tick("t2");
    drive(4'b0010, 4'b0010, 4'b0000, 1'b0, 1'b0, 1'b0); tick("t2");
    check_val("t2_gnt_c", 32'(bus.gnt_o), 32'b0010);

    // 3: after two acks m0 is pre-empted by waiting m2.
    apply_reset();
    drive(4'b0001, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0); tick("t3");
    drive(4'b0101, 4'b0101, 4'b0000, 1'b1, 1'b0, 1'b0); tick("t3");
    check_val("t3_hold", 32'(bus.gnt_o), 32'b0001);
    tick("t3");
    check_val("t3_preempt", 32'(bus.gnt_o), 32'b0100);

    // 4: locked owner keeps the bus through 20 acks while m3 waits.
    apply_reset();
    drive(4'b0010, 4'b0010, 4'b0010, 1'b0, 1'b0, 1'b0); tick("t4");
    drive(4'b1010, 4'b1010, 4'b0010, 1'b1, 1'b0, 1'b0);
    repeat (20) tick("t4");
    check_val("t4_gnt_locked", 32'(bus.gnt_o), 32'b0010);
    check_val("t4_locked", 32'(bus.locked_o), 32'h1);
    drive(4'b1000, 4'b1000, 4'b0000, 1'b0, 1'b0, 1'b0); tick("t4");
    check_val("t4_handover", 32'(bus.gnt_o), 32'b1000);
    check_val("t4_unlocked", 32'(bus.locked_o), 32'h0);

    // 5: watchdog revokes a stalled m0, masks it, then serves m1.
    apply_reset();
    drive(4'b0011, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0); tick("t5");
    check_val("t5_gnt0", 32'(bus.gnt_o), 32'b0001);
    repeat (15) tick("t5");
    check_val("t5_no_tmo_yet", 32'(bus.tmo_err_o), 32'h0);
    tick("t5");
    check_val("t5_tmo_pulse", 32'(bus.tmo_err_o), 32'h1);
    check_val("t5_gnt_during_tmo", 32'(bus.gnt_o), 32'b0001);
    tick("t5");
    check_val("t5_gnt_dropped", 32'(bus.gnt_o), 32'h0);
    check_val("t5_tmo_once", 32'(bus.tmo_err_o), 32'h0);
    tick("t5");
    check_val("t5_m1", 32'(bus.gnt_o), 32'b0010);
    drive(4'b0001, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0); tick("t5");
    check_val("t5_m0_masked", 32'(bus.gnt_o), 32'h0);
    drive(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0); tick("t5");
    drive(4'b0001, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0); tick("t5");
    check_val("t5_m0_unmasked", 32'(bus.gnt_o), 32'b0001);

    // 6: async reset in the middle of a locked burst clears outputs at once.
    apply_reset();
    drive(4'b0100, 4'b0100, 4'b0100, 1'b0, 1'b0, 1'b0); tick("t6");
    drive(4'b1100, 4'b1100, 4'b0100, 1'b1, 1'b0, 1'b0);
    repeat (3) tick("t6");
    check_val("t6_locked_before", 32'(bus.locked_o), 32'h1);
    #2 rst_ni = 1'b0;
    #1;
    model_reset();
    check_val("t6_async_gnt",    32'(bus.gnt_o),       32'h0);
    check_val("t6_async_valid",  32'(bus.gnt_valid_o), 32'h0);
    check_val("t6_async_locked", 32'(bus.locked_o),    32'h0);
    check_val("t6_async_tmo",    32'(bus.tmo_err_o),   32'h0);
    @(negedge clk);
    check_outputs("t6_rst");
    drive('0, '0, '0, 1'b0, 1'b0, 1'b0);
    rst_ni = 1'b1;
    tick("t6_after");

    // Randomized traffic: alternating normal and slave-stall phases.
    rc = '0;
    want_lock = '0;
    for (int n = 0; n < 4000; n++) begin
      quiet = ((n / 250) % 3) == 2;
      for (int i = 0; i < N; i++) begin
        if (!rc[i]) begin
          if ($urandom_range(3) == 0) begin
            rc[i] = 1'b1;
            want_lock[i] = ($urandom_range(5) == 0);
          end
        end else if ($urandom_range(quiet ? 39 : 11) == 0) begin
          rc[i] = 1'b0;
        end else if (want_lock[i] && $urandom_range(15) == 0) begin
          want_lock[i] = 1'b0;
        end
        rs[i] = rc[i] & (quiet || $urandom_range(7) != 0);
        rl[i] = rc[i] & want_lock[i];
      end
      if (quiet)
        drive(rc, rs, rl, $urandom_range(49) == 0, 1'b0, 1'b0);
      else
        drive(rc, rs, rl, $urandom_range(2) == 0, $urandom_range(29) == 0, $urandom_range(29) == 0);
      tick("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
